matvec_q: RTL

Parametrised fixed-point vector × matrix engine, the successor to the team's first-generation matmul block in the RNN accelerator datapath. It computes out[j] = Σ_i vec[i]·mat[i][j] for N = 2^IN_BITS inputs and M = 2^OUT_BITS outputs. Operands stream from external synchronous RAMs with 1-cycle read latency. Products accumulate at full precision; rescaling, saturation and optional ReLU are applied only at readout. An accumulate mode lets successive calls sum into the existing results, for example an input term followed by a recurrent term.

---
 rtl/matvec_q.sv | 124 ++++++++++++
 1 files changed

// File: rtl/matvec_q.sv
// Fixed-point vector x matrix engine: streams operands from 1-cycle-latency RAMs,
// accumulates full-precision products per column, and rescales/saturates/ReLUs at readout.
module matvec_q #(
   parameter int DATA_W    = 16,
   parameter int FRAC_BITS = 8,
   parameter int IN_BITS   = 2,
   parameter int OUT_BITS  = 4,
   parameter int ACC_W     = 40
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                acc_en,
   input  logic                relu_en,
   output logic [IN_BITS-1:0]  vec_addr,
   output logic [IN_BITS-1:0]  row_addr,
   output logic [OUT_BITS-1:0] col_addr,
   output logic                rd_en,
   input  logic [DATA_W-1:0]   vec_data,
   input  logic [DATA_W-1:0]   mat_data,
   output logic                busy,
   output logic                done,
   input  logic [OUT_BITS-1:0] rd_sel,
   output logic [DATA_W-1:0]   data_out,
   output logic                data_sat
);

   localparam int CNT_W = IN_BITS + OUT_BITS;
   localparam int M     = 1 << OUT_BITS;
   localparam int PW    = 2 * DATA_W;

   localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      rd_en_q, rd_en_d;
   logic                      relu_q, relu_d;
   logic                      valid_q;
   logic [OUT_BITS-1:0]       jd_q;
   logic signed [ACC_W-1:0]   acc_q [M];
   logic signed [PW-1:0]      prod;
   logic signed [ACC_W-1:0]   prodExt;
   logic signed [ACC_W-1:0]   shifted;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      relu_d  = relu_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               relu_d  = relu_en;
               state_d = acc_en ? RUN : CLEAR;
            end
         end
         CLEAR: state_d = RUN;
         RUN: begin
            // The read counter wraps back to 0 after the last read, so addresses rest at 0.
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) state_d = DRAIN;
         end
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      rd_en_d = (state_d == RUN);
   end

   assign prod    = PW'($signed(vec_data)) * PW'($signed(mat_data));
   assign prodExt = {{(ACC_W-PW){prod[PW-1]}}, prod};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rd_en_q <= 1'b0;
         relu_q  <= 1'b0;
         valid_q <= 1'b0;
         jd_q    <= '0;
         for (int j = 0; j < M; j++) acc_q[j] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_en_q <= rd_en_d;
         relu_q  <= relu_d;
         // Column index travels with the read so it lines up with the returning data.
         valid_q <= rd_en_q;
         jd_q    <= cnt_q[OUT_BITS-1:0];
         if (state_q == CLEAR) begin
            for (int j = 0; j < M; j++) acc_q[j] <= '0;
         end else if (valid_q) begin
            acc_q[jd_q] <= acc_q[jd_q] + prodExt;
         end
      end
   end

   assign vec_addr = cnt_q[CNT_W-1:OUT_BITS];
   assign row_addr = cnt_q[CNT_W-1:OUT_BITS];
   assign col_addr = cnt_q[OUT_BITS-1:0];
   assign rd_en    = rd_en_q;
   assign busy     = (state_q == CLEAR) || (state_q == RUN) || (state_q == DRAIN);
   assign done     = (state_q == DONE);

   always_comb begin
      shifted  = acc_q[rd_sel] >>> FRAC_BITS;
      data_out = shifted[DATA_W-1:0];
      data_sat = 1'b0;
      if (shifted > SAT_HI) begin
         data_out = SAT_HI[DATA_W-1:0];
         data_sat = 1'b1;
      end else if (shifted < SAT_LO) begin
         data_out = SAT_LO[DATA_W-1:0];
         data_sat = 1'b1;
      end
      if (relu_q && shifted[ACC_W-1]) begin
         data_out = '0;
         data_sat = 1'b0;
      end
   end

endmodule
